// File: rtl/menu_pkg.sv
// Shared types and mode-stepping helpers for the display menu controller.
// Encodings match the selects expected by the per-source and source data muxes.
package menu_pkg;

    typedef enum logic [1:0] {
        SRC_XADC = 2'b00,
        SRC_PWM  = 2'b01,
        SRC_R2R  = 2'b10
    } source_e;

    typedef enum logic [1:0] {
        DATA_RAW    = 2'b01,
        DATA_AVG    = 2'b10,
        DATA_SCALED = 2'b11
    } data_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } ctrl_state_e;

    function automatic source_e next_source(input source_e cur);
        case (cur)
            SRC_XADC: next_source = SRC_PWM;
            SRC_PWM:  next_source = SRC_R2R;
            SRC_R2R:  next_source = SRC_XADC;
            default:  next_source = SRC_XADC;
        endcase
    endfunction

    function automatic data_e next_data(input data_e cur);
        case (cur)
            DATA_RAW:    next_data = DATA_AVG;
            DATA_AVG:    next_data = DATA_SCALED;
            DATA_SCALED: next_data = DATA_RAW;
            default:     next_data = DATA_RAW;
        endcase
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw pushbutton to single-cycle press pulse: 2-FF synchronizer, consecutive-cycle
// debounce, and rising-edge detector on the debounced level.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, debounce and edge-detect; any agreeing cycle restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            press_r   <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync1_r   <= btn;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            press_r   <= level_r & ~level_d_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/menu_controller.sv
// Menu sequencing controller: turns three pushbuttons and a scan switch into
// registered source/data selects with a hold (freeze) state and timed auto-scan.
module menu_controller
    import menu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SCAN_CYCLES     = 200_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_source,
    input  logic       btn_data,
    input  logic       btn_hold,
    input  logic       scan_en,
    output logic [1:0] display_source,
    output logic [1:0] display_data,
    output logic       hold_active,
    output logic       capture,
    output logic       mode_changed
);

    localparam int TMR_W = $clog2(SCAN_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCAN_CYCLES - 1);

    logic             press_source_s;
    logic             press_data_s;
    logic             press_hold_s;
    logic             scan_sync1_r;
    logic             scan_sync2_r;

    ctrl_state_e      state_r;
    ctrl_state_e      state_s;
    source_e          source_r;
    source_e          source_s;
    data_e            data_r;
    data_e            data_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_s;
    logic             capture_r;
    logic             capture_s;
    logic             mode_changed_r;
    logic             mode_changed_s;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_source (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_source),
        .press (press_source_s)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_data (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_data),
        .press (press_data_s)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_hold (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_hold),
        .press (press_hold_s)
    );

    // scan_en is a level switch, so it only needs synchronizing.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_sync1_r <= 1'b0;
            scan_sync2_r <= 1'b0;
        end else begin
            scan_sync1_r <= scan_en;
            scan_sync2_r <= scan_sync1_r;
        end
    end

    // Next-state: hold toggles dominate, manual presses beat a coincident scan tick.
    always_comb begin
        state_s   = state_r;
        source_s  = source_r;
        data_s    = data_r;
        timer_s   = timer_r;
        capture_s = 1'b0;
        case (state_r)
            RUN: begin
                if (press_hold_s) begin
                    state_s   = HOLD;
                    capture_s = 1'b1;
                end else if (press_source_s || press_data_s) begin
                    timer_s = '0;
                    if (press_source_s) begin
                        source_s = next_source(source_r);
                    end else begin
                        source_s = source_r;
                    end
                    if (press_data_s) begin
                        data_s = next_data(data_r);
                    end else begin
                        data_s = data_r;
                    end
                end else if (scan_sync2_r) begin
                    if (timer_r == TMR_LAST) begin
                        timer_s = '0;
                        data_s  = next_data(data_r);
                        if (data_r == DATA_SCALED) begin
                            source_s = next_source(source_r);
                        end else begin
                            source_s = source_r;
                        end
                    end else begin
                        timer_s = timer_r + 1'b1;
                    end
                end else begin
                    timer_s = '0;
                end
            end
            HOLD: begin
                if (press_hold_s) begin
                    state_s = RUN;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = RUN;
            end
        endcase
        mode_changed_s = (source_s != source_r) || (data_s != data_r);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= RUN;
            source_r       <= SRC_XADC;
            data_r         <= DATA_RAW;
            timer_r        <= '0;
            capture_r      <= 1'b0;
            mode_changed_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            source_r       <= source_s;
            data_r         <= data_s;
            timer_r        <= timer_s;
            capture_r      <= capture_s;
            mode_changed_r <= mode_changed_s;
        end
    end

    assign display_source = source_r;
    assign display_data   = data_r;
    assign hold_active    = (state_r == HOLD);
    assign capture        = capture_r;
    assign mode_changed   = mode_changed_r;

endmodule

// File: tb/tb_menu_controller.sv
// Directed and random stimulus for menu_controller, checked every cycle against
// a mode-index reference model, plus explicit checks at the key timing points.
module tb_menu_controller;

    localparam int D = 4;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_source = 1'b0;
    logic       btn_data = 1'b0;
    logic       btn_hold = 1'b0;
    logic       scan_en = 1'b0;
    logic [1:0] display_source;
    logic [1:0] display_data;
    logic       hold_active;
    logic       capture;
    logic       mode_changed;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cap_seen = 0;
    int mc_seen = 0;

    // reference model: source 0..2, data 0..2 (display code = data+1)
    int m_s1[3], m_s2[3], m_run[3], m_lvl[3], m_lvl_d[3], m_pulse[3];
    int m_sc1, m_sc2, m_src, m_dat, m_timer, m_hold, m_cap, m_chg;

    menu_controller #(.DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_source     (btn_source),
        .btn_data       (btn_data),
        .btn_hold       (btn_hold),
        .scan_en        (scan_en),
        .display_source (display_source),
        .display_data   (display_data),
        .hold_active    (hold_active),
        .capture        (capture),
        .mode_changed   (mode_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update();
        int raw[3];
        int ns, nd, idx;
        raw = '{int'(btn_source), int'(btn_data), int'(btn_hold)};
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_run[b] = 0;
                m_lvl[b] = 0; m_lvl_d[b] = 0; m_pulse[b] = 0;
            end
            m_sc1 = 0; m_sc2 = 0; m_src = 0; m_dat = 0;
            m_timer = 0; m_hold = 0; m_cap = 0; m_chg = 0;
        end else begin
            ns = m_src;
            nd = m_dat;
            m_cap = 0;
            if (m_hold == 0) begin
                if (m_pulse[2] != 0) begin
                    m_hold = 1;
                    m_cap = 1;
                end else if (m_pulse[0] != 0 || m_pulse[1] != 0) begin
                    m_timer = 0;
                    if (m_pulse[0] != 0) ns = (m_src + 1) % 3;
                    if (m_pulse[1] != 0) nd = (m_dat + 1) % 3;
                end else if (m_sc2 != 0) begin
                    if (m_timer == S - 1) begin
                        m_timer = 0;
                        idx = (m_src * 3 + m_dat + 1) % 9;
                        ns = idx / 3;
                        nd = idx % 3;
                    end else begin
                        m_timer++;
                    end
                end else begin
                    m_timer = 0;
                end
            end else if (m_pulse[2] != 0) begin
                m_hold = 0;
            end
            m_chg = (ns != m_src || nd != m_dat) ? 1 : 0;
            m_src = ns;
            m_dat = nd;
            for (int b = 0; b < 3; b++) begin
                m_pulse[b] = (m_lvl[b] != 0 && m_lvl_d[b] == 0) ? 1 : 0;
                m_lvl_d[b] = m_lvl[b];
                if (m_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_lvl[b] = m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
            m_sc2 = m_sc1;
            m_sc1 = int'(scan_en);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        if (capture === 1'b1) cap_seen++;
        if (mode_changed === 1'b1) mc_seen++;
        chk("model_source", 32'(display_source), 32'(m_src));
        chk("model_data", 32'(display_data), 32'(m_dat + 1));
        chk("model_hold", 32'(hold_active), 32'(m_hold));
        chk("model_capture", 32'(capture), 32'(m_cap));
        chk("model_mode_changed", 32'(mode_changed), 32'(m_chg));
    endtask

    task automatic press(input logic s, input logic d, input logic h, input int hi, input int lo);
        btn_source = s; btn_data = d; btn_hold = h;
        repeat (hi) step();
        btn_source = 1'b0; btn_data = 1'b0; btn_hold = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        int s0, d0, bound, seen;
        int chg_cyc[$];
        int chg_src[$];
        int chg_dat[$];

        // reset state
        repeat (3) step();
        chk("reset_source", 32'(display_source), 32'd0);
        chk("reset_data", 32'(display_data), 32'd1);
        chk("reset_hold", 32'(hold_active), 32'd0);
        reset = 1'b0;
        repeat (3) step();

        // test 1: data press, exact latency D+4
        mc_seen = 0;
        btn_data = 1'b1;
        repeat (D + 3) step();
        chk("t1_data_before", 32'(display_data), 32'd1);
        step();
        chk("t1_data_after", 32'(display_data), 32'd2);
        chk("t1_mode_changed", 32'(mode_changed), 32'd1);
        step();
        chk("t1_pulse_single", 32'(mode_changed), 32'd0);
        btn_data = 1'b0;
        repeat (10) step();
        chk("t1_source_stays", 32'(display_source), 32'd0);
        chk("t1_one_pulse", 32'(mc_seen), 32'd1);
        press(1'b0, 1'b1, 1'b0, 10, 10);
        chk("t1_data_scaled", 32'(display_data), 32'd3);
        press(1'b0, 1'b1, 1'b0, 10, 10);
        chk("t1_data_wrap", 32'(display_data), 32'd1);

        // test 2: short glitches never reach the debounced level
        mc_seen = 0;
        press(1'b1, 1'b0, 1'b0, D - 1, 1);
        press(1'b1, 1'b0, 1'b0, D - 1, 12);
        chk("t2_source_stays", 32'(display_source), 32'd0);
        chk("t2_no_pulse", 32'(mc_seen), 32'd0);

        // test 3: auto-scan through all nine modes
        reset = 1'b1;
        scan_en = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        bound = 0;
        while (chg_cyc.size() < 10 && bound < 120) begin
            step();
            bound++;
            if (mode_changed === 1'b1) begin
                chg_cyc.push_back(cyc);
                chg_src.push_back(int'(display_source));
                chg_dat.push_back(int'(display_data));
            end
        end
        chk("t3_step_count", 32'(chg_cyc.size()), 32'd10);
        for (int k = 0; k < chg_cyc.size(); k++) begin
            chk("t3_source_seq", 32'(chg_src[k]), 32'(((k + 1) % 9) / 3));
            chk("t3_data_seq", 32'(chg_dat[k]), 32'(((k + 1) % 9) % 3 + 1));
            if (k > 0) chk("t3_interval", 32'(chg_cyc[k] - chg_cyc[k-1]), 32'(S));
        end

        // test 4: hold freezes everything, single capture
        cap_seen = 0;
        press(1'b0, 1'b0, 1'b1, 10, 2);
        chk("t4_hold_on", 32'(hold_active), 32'd1);
        chk("t4_capture_once", 32'(cap_seen), 32'd1);
        s0 = int'(display_source);
        d0 = int'(display_data);
        mc_seen = 0;
        press(1'b1, 1'b0, 1'b0, 10, 10);
        press(1'b0, 1'b1, 1'b0, 10, 10);
        repeat (20) step();
        chk("t4_frozen_source", 32'(display_source), 32'(s0));
        chk("t4_frozen_data", 32'(display_data), 32'(d0));
        chk("t4_no_change", 32'(mc_seen), 32'd0);
        press(1'b0, 1'b0, 1'b1, 10, 2);
        chk("t4_hold_off", 32'(hold_active), 32'd0);
        chk("t4_no_capture_on_exit", 32'(cap_seen), 32'd1);
        repeat (20) step();

        // test 5: coincident presses
        scan_en = 1'b0;
        repeat (4) step();
        s0 = int'(display_source);
        d0 = int'(display_data);
        mc_seen = 0;
        press(1'b1, 1'b1, 1'b0, 10, 10);
        chk("t5_both_source", 32'(display_source), 32'((s0 + 1) % 3));
        chk("t5_both_data", 32'(display_data), 32'(d0 % 3 + 1));
        chk("t5_one_change", 32'(mc_seen), 32'd1);
        d0 = int'(display_data);
        press(1'b0, 1'b1, 1'b1, 10, 10);
        chk("t5_hold_wins", 32'(hold_active), 32'd1);
        chk("t5_data_dropped", 32'(display_data), 32'(d0));
        press(1'b0, 1'b0, 1'b1, 10, 10);
        chk("t5_hold_exit", 32'(hold_active), 32'd0);

        // test 6: manual press coincident with scan terminal count
        scan_en = 1'b1;
        repeat (5) step();
        bound = 0;
        while (m_timer != 0 && bound < 20) begin
            step();
            bound++;
        end
        chk("t6_align_bound", 32'(m_timer), 32'd0);
        s0 = int'(display_source);
        d0 = int'(display_data);
        btn_data = 1'b1;
        repeat (D + 4) step();
        chk("t6_data_once", 32'(display_data), 32'(d0 % 3 + 1));
        chk("t6_source_kept", 32'(display_source), 32'(s0));
        mc_seen = 0;
        seen = 0;
        for (int i = 0; i < S; i++) begin
            if (i == 2) btn_data = 1'b0;
            step();
            if (i == S - 1) seen = int'(mode_changed);
        end
        chk("t6_no_early_step", 32'(mc_seen), 32'd1);
        chk("t6_next_step_at_S", 32'(seen), 32'd1);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("t6_reset_source", 32'(display_source), 32'd0);
        chk("t6_reset_data", 32'(display_data), 32'd1);
        reset = 1'b0;
        scan_en = 1'b0;

        // random phase against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) btn_source = ~btn_source;
            if ($urandom_range(0, 5) == 0) btn_data = ~btn_data;
            if ($urandom_range(0, 7) == 0) btn_hold = ~btn_hold;
            if ($urandom_range(0, 39) == 0) scan_en = ~scan_en;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/menu_controller.md
# menu_controller

Sequencing controller for the display menu datapath. Converts three raw pushbuttons and a scan-enable switch into registered source and data-type selects (XADC / PWM / R2R × RAW / AVERAGED / SCALED) that drive the per-source data muxes and the source mux. Provides a hold/freeze state and an optional timed auto-scan through all nine display modes. It replaces direct switch-coded mode selection ahead of the menu datapath.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be ≥ 2.
- SCAN_CYCLES, 200_000_000: dwell per mode in auto-scan (2 s at 100 MHz); must be ≥ 2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- btn_source  in  1  raw asynchronous pushbutton: next source.
- btn_data  in  1  raw asynchronous pushbutton: next data type.
- btn_hold  in  1  raw asynchronous pushbutton: toggle hold.
- scan_en  in  1  slide switch, level; enables auto-scan. Synchronized only, not debounced.
- display_source  out  2  00 XADC, 01 PWM, 10 R2R; 11 is never driven.
- display_data  out  2  01 RAW, 10 AVERAGED, 11 SCALED; 00 is never driven. The downstream decimal-point logic keys on 11.
- hold_active  out  1  high while in HOLD.
- capture  out  1  one-cycle pulse on the cycle HOLD is entered; the downstream snapshot register latches on it.
- mode_changed  out  1  one-cycle pulse coincident with any change of display_source or display_data.

## Operation
- Button conditioning, per button:
  - 2-FF synchronizer.
  - Debounced level changes when the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - A press pulse asserts for 1 cycle on the cycle after the debounced level rises. Releases generate nothing.
- Source press: cycles XADC→PWM→R2R→XADC.
- Data press: cycles RAW→AVG→SCALED→RAW.
- Source and data presses in the same cycle both apply.
- FSM states:
  - RUN → HOLD on a hold press; capture pulses.
  - HOLD → RUN on a hold press.
  - Reset state: RUN.
- In HOLD:
  - Source and data presses are ignored.
  - The scan timer is frozen at its current value.
  - Outputs remain constant.
- A hold press coincident with a source or data press: the hold toggle takes effect and the other presses are dropped, in both directions.
- Auto-scan, active in RUN with synchronized scan_en = 1:
  - The timer counts 0..SCAN_CYCLES−1.
  - At terminal count it wraps to 0 and advances the mode: data steps first; on the SCALED→RAW wrap, source also steps.
  - Full cycle is 9 modes, e.g. (R2R,SCALED) → (XADC,RAW).
- Manual source or data press in RUN resets the scan timer to 0. A scan tick in the same cycle is discarded and the manual press wins.
- scan_en = 0 holds the timer at 0.
- Reset values:
  - display_source = 00, display_data = 01.
  - hold_active = 0, capture = 0, mode_changed = 0.
  - All counters = 0; debounced levels = 0; synchronizers = 0.
- A button held through reset is seen as a new press once debounced after reset. This is required behaviour.
- Reset asserted mid-debounce or mid-scan discards all progress.

## Timing
- All outputs are registered.
- Press pulse at cycle k → display_source/display_data/mode_changed update at k+1.
- Hold press at k → hold_active and capture at k+1.
- Raw button rising edge (clean) at cycle 0 → outputs update at cycle DEBOUNCE_CYCLES+4: 2 sync, DEBOUNCE_CYCLES count, 1 edge, 1 output.
- Scan terminal count at cycle t → outputs change at t+1.
- Successive scan steps are exactly SCAN_CYCLES apart absent presses.

## Structure
- Package menu_pkg:
  - source_e enum {SRC_XADC=2'b00, SRC_PWM=2'b01, SRC_R2R=2'b10}.
  - data_e enum {DATA_RAW=2'b01, DATA_AVG=2'b10, DATA_SCALED=2'b11}.
  - ctrl_state_e {RUN, HOLD}.
  - Functions next_source() and next_data().
- Sub-module button_conditioner, parameterized by DEBOUNCE_CYCLES:
  - Contains the synchronizer, debounce counter and rise detector.
  - Instantiated three times.
  - scan_en uses a bare 2-FF synchronizer.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, SCAN_CYCLES=8.

1. Reset, then clean btn_data press held 10 cycles → display_data 01→10 exactly 8 cycles after the edge, one mode_changed pulse, display_source stays 00; three presses return to 01.
2. btn_source glitch high for 3 cycles, then low → no output change, no pulses; counter cleared.
3. scan_en=1 from reset → mode steps every 8 cycles through all 9 modes and wraps from (10,11) to (00,01).
4. Hold press → hold_active=1 with a single capture pulse; source/data presses and scan produce no changes; second hold press → RUN, and scan resumes from the frozen timer value.
5. btn_source and btn_data pressed the same cycle → both advance together, one mode_changed; hold+data pressed the same cycle → HOLD entered, data unchanged.
6. Manual data press coincident with scan terminal count → data advances once (not twice), and the next scan step occurs 8 cycles later; reset asserted mid-scan → outputs return to (00,01) next cycle.
